gray_counter: RTL and testbench

- Parameterised up/down counter that produces a registered Gray-code count, plus the matching binary count.
- It is the stage directly upstream of the team's gray-to-binary converter (g_to_b_conv): its `gray` output drives that converter's `g` input.
- It provides the single-bit-change sequence used for pointer and position encoding.
- It also provides a synchronous load, a direction control and a one-cycle wrap flag.

---
 rtl/gray_counter.sv | 61 ++++++
 tb/tb_gray_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with registered Gray and binary counts, sync load and wrap flag
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] next_bin;
    logic             step_wrap;
    logic             next_wrap;

    // one count step in the requested direction and whether it crosses the range boundary
    always_comb begin
        step_bin  = up_dn ? bin + WIDTH'(1) : bin - WIDTH'(1);
        step_wrap = up_dn ? &bin : ~|bin;
    end

    // load beats count beats hold; wrap only survives a real count step
    always_comb begin
        next_bin  = load ? load_bin : en ? step_bin : bin;
        next_wrap = !load && en && step_wrap;
    end

    // gray is encoded from the same next value as bin so the two can never disagree
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= next_bin ^ (next_bin >> 1);
            wrap <= next_wrap;
        end
    end

endmodule

// g_to_b_conv: combinational Gray-to-binary decode, each bit is the XOR of all Gray bits at or above it
module g_to_b_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^(g >> i);
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and random checks of gray_counter against an arithmetic model
module tb_gray_counter;

    localparam int W = 4;
    localparam int N = 1 << W;
    localparam int OP_RST = 0, OP_LOAD = 1, OP_CNT = 2, OP_HOLD = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         wrap;
    logic [W-1:0] conv;

    int n_checks = 0;
    int n_fail = 0;

    int           m_bin = 0;
    logic         m_wrap = 1'b0;
    int           m_op = OP_RST;
    logic         m_valid = 1'b0;
    logic [W-1:0] prev_gray = '0;

    logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    gray_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .gray(gray), .bin(bin), .wrap(wrap)
    );

    g_to_b_conv #(.WIDTH(W)) conv_i (.g(gray), .b(conv));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: plain modular arithmetic on an integer count
    always @(posedge clk) begin
        prev_gray <= gray;
        if (!rst_n) begin
            m_bin <= 0; m_wrap <= 1'b0; m_op <= OP_RST; m_valid <= 1'b1;
        end else if (load) begin
            m_bin <= int'(load_bin); m_wrap <= 1'b0; m_op <= OP_LOAD;
        end else if (en) begin
            m_bin  <= up_dn ? (m_bin + 1) % N : (m_bin + N - 1) % N;
            m_wrap <= up_dn ? (m_bin + 1 >= N) : (m_bin == 0);
            m_op   <= OP_CNT;
        end else begin
            m_wrap <= 1'b0; m_op <= OP_HOLD;
        end
    end

    // every-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            logic [W-1:0] eb;
            eb = W'(m_bin);
            chk("model_bin", 32'(bin), 32'(eb));
            chk("model_gray", 32'(gray), 32'(eb ^ (eb >> 1)));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("loopback_conv", 32'(conv), 32'(bin));
            if (m_op == OP_CNT) chk("count_one_bit", $countones(gray ^ prev_gray), 1);
            if (m_op == OP_HOLD) chk("hold_no_bit", $countones(gray ^ prev_gray), 0);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic u, input logic l, input logic [W-1:0] lb);
        rst_n = r; en = e; up_dn = u; load = l; load_bin = lb;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] g, input logic [W-1:0] b, input logic w);
        chk({name, "_gray"}, 32'(gray), 32'(g));
        chk({name, "_bin"}, 32'(bin), 32'(b));
        chk({name, "_wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t required under 100000", $time);
        $fatal(1);
    end

    initial begin
        cyc(0, 1, 1, 1, 4'hA);
        cyc(0, 0, 0, 0, 4'h0);
        expect_out("reset", 4'h0, 4'h0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 1, 1, 0, 4'h0);
            expect_out($sformatf("up%0d", i), gseq[i], 4'(i), i == 16);
        end
        cyc(0, 0, 0, 0, 4'h0);
        cyc(1, 1, 0, 0, 4'h0);
        expect_out("down_wrap", 4'b1000, 4'b1111, 1'b1);
        cyc(1, 1, 0, 0, 4'h0);
        expect_out("down_next", 4'b1001, 4'b1110, 1'b0);
        cyc(1, 0, 0, 1, 4'b1010);
        expect_out("load_a", 4'b1111, 4'b1010, 1'b0);
        cyc(1, 1, 1, 1, 4'b1111);
        expect_out("load_wins", 4'b1000, 4'b1111, 1'b0);
        cyc(1, 0, 0, 1, 4'b0101);
        expect_out("load_5", 4'b0111, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 4'h0);
            expect_out($sformatf("hold%0d", i), 4'b0111, 4'b0101, 1'b0);
        end
        cyc(1, 1, 1, 0, 4'h0);
        expect_out("dir_up", 4'b0101, 4'b0110, 1'b0);
        cyc(1, 1, 0, 0, 4'h0);
        expect_out("dir_dn", 4'b0111, 4'b0101, 1'b0);
        cyc(1, 1, 1, 0, 4'h0);
        expect_out("dir_up2", 4'b0101, 4'b0110, 1'b0);
        cyc(1, 1, 1, 0, 4'h0);
        expect_out("at_7", 4'b0100, 4'b0111, 1'b0);
        cyc(0, 1, 1, 1, 4'b1010);
        expect_out("mid_reset", 4'h0, 4'h0, 1'b0);
        cyc(1, 1, 1, 0, 4'h0);
        expect_out("post_reset", 4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 200; i++)
            cyc(1, 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0, W'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
